// File: rtl/motion_cntrl_par.sv
// Line-follower motion controller: scans IR sensor pairs through an external A2D,
// forms a weighted position error and drives PI-corrected left/right motor commands.

module motion_cntrl_par #(
    parameter int          NUM_PAIRS  = 3,
    parameter int          SETTLE_CYC = 4096,
    parameter int          GAP_CYC    = 32,
    parameter int          INT_DEC    = 4,
    parameter logic [11:0] FWD_MAX    = 12'h700,
    parameter logic [7:0]  IR_DUTY    = 8'h8C
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 go,
    input  logic                 cnv_cmplt,
    input  logic [11:0]          A2D_res,
    input  logic [7:0]           Kp,
    input  logic [7:0]           Ki,
    output logic                 strt_cnv,
    output logic [2:0]           chnnl,
    output logic [NUM_PAIRS-1:0] IR_en,
    output logic [7:0]           LEDs,
    output logic [10:0]          lft,
    output logic [10:0]          rht,
    output logic                 loop_done
);

    // state   | meaning
    // IDLE    | waiting for go; loop_done pulses here after LFT
    // SETTLE  | emitter of current pair on, settle timer running
    // CNV_IN  | inner sensor conversion requested, waiting for cnv_cmplt
    // GAP     | pause between inner result and outer conversion
    // CNV_OUT | outer sensor conversion requested, waiting for cnv_cmplt
    // INTG    | decimated integrator and forward-speed update
    // PCALC   | proportional term
    // ICALC   | integral term
    // RHT     | right motor command
    // LFT     | left motor command

    typedef enum logic [3:0] {
        IDLE, SETTLE, CNV_IN, GAP, CNV_OUT, INTG, PCALC, ICALC, RHT, LFT
    } state_t;

    localparam int               TMR_MAX   = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
    localparam int               TMR_W     = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LD    = TMR_W'(GAP_CYC - 1);
    localparam logic [1:0]       PAIR_LAST = 2'(NUM_PAIRS - 1);
    localparam logic [3:0]       DEC_LAST  = 4'(INT_DEC - 1);

    state_t             state, state_nxt;
    logic               strt_nxt;
    logic [TMR_W-1:0]   tmr;
    logic [1:0]         pair;
    logic [3:0]         dec_cnt;
    logic [7:0]         pwm_cnt;
    logic               last_pair;
    logic               scan_act;

    logic signed [15:0] accum, samp_sh, accum_in, accum_out;
    logic signed [11:0] error, intgrl, pcomp, icomp, lft_reg, rht_reg;
    logic [11:0]        fwd;
    logic signed [12:0] i_sum;
    logic signed [20:0] err_x, intg_x, kp_x, ki_x, p_prod, i_prod, p_sh, i_sh;
    logic signed [13:0] r_sum, l_sum;

    function automatic logic signed [11:0] sat12(input logic signed [23:0] v);
        if (v > 24'sd2047)
            return 12'sh7FF;
        else if (v < -24'sd2048)
            return 12'sh800;
        else
            return v[11:0];
    endfunction

    assign last_pair = (pair == PAIR_LAST);
    assign scan_act  = (state == SETTLE) || (state == CNV_IN) ||
                       (state == GAP) || (state == CNV_OUT);

    // Outer-pair samples carry more weight so off-centre error grows faster
    assign samp_sh   = {4'b0000, A2D_res} << pair;
    assign accum_in  = accum + samp_sh;
    assign accum_out = accum - samp_sh;

    assign i_sum  = {intgrl[11], intgrl} + {{5{error[11]}}, error[11:4]};
    assign err_x  = {{9{error[11]}}, error};
    assign intg_x = {{9{intgrl[11]}}, intgrl};
    assign kp_x   = {13'b0, Kp};
    assign ki_x   = {13'b0, Ki};
    assign p_prod = err_x * kp_x;
    assign i_prod = intg_x * ki_x;
    assign p_sh   = p_prod >>> 4;
    assign i_sh   = i_prod >>> 4;
    assign r_sum  = {2'b00, fwd} - {{2{pcomp[11]}}, pcomp} - {{2{icomp[11]}}, icomp};
    assign l_sum  = {2'b00, fwd} + {{2{pcomp[11]}}, pcomp} + {{2{icomp[11]}}, icomp};

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        strt_nxt  = 1'b0;
        case (state)
            IDLE:    if (go) state_nxt = SETTLE;
            SETTLE:  if (tmr == '0) state_nxt = CNV_IN;
            CNV_IN:  if (cnv_cmplt) state_nxt = GAP;
            GAP:     if (tmr == '0) state_nxt = CNV_OUT;
            CNV_OUT: if (cnv_cmplt) state_nxt = last_pair ? INTG : SETTLE;
            INTG:    state_nxt = PCALC;
            PCALC:   state_nxt = ICALC;
            ICALC:   state_nxt = RHT;
            RHT:     state_nxt = LFT;
            LFT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (!go)
            state_nxt = IDLE;
        if ((state_nxt == CNV_IN && state != CNV_IN) ||
            (state_nxt == CNV_OUT && state != CNV_OUT))
            strt_nxt = 1'b1;
    end

    always_comb begin
        chnnl = 3'd0;
        IR_en = '0;
        if (state == SETTLE || state == CNV_IN)
            chnnl = {pair, 1'b0};
        else if (state == GAP || state == CNV_OUT)
            chnnl = {pair, 1'b1};
        for (int i = 0; i < NUM_PAIRS; i++)
            IR_en[i] = scan_act && (pair == 2'(i)) && (pwm_cnt < IR_DUTY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            strt_cnv  <= 1'b0;
            loop_done <= 1'b0;
            tmr       <= '0;
            pair      <= 2'd0;
            dec_cnt   <= 4'd0;
            pwm_cnt   <= 8'd0;
            accum     <= '0;
            error     <= '0;
            intgrl    <= '0;
            pcomp     <= '0;
            icomp     <= '0;
            fwd       <= '0;
            lft_reg   <= '0;
            rht_reg   <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + 8'd1;
            strt_cnv  <= strt_nxt;
            loop_done <= go && (state == LFT);

            if (state_nxt == SETTLE && state != SETTLE)
                tmr <= SETTLE_LD;
            else if (state_nxt == GAP && state != GAP)
                tmr <= GAP_LD;
            else if (tmr != '0)
                tmr <= tmr - 1'b1;

            if (!go) begin
                fwd     <= '0;
                intgrl  <= '0;
                lft_reg <= '0;
                rht_reg <= '0;
                accum   <= '0;
                dec_cnt <= 4'd0;
                pair    <= 2'd0;
            end else begin
                case (state)
                    IDLE: begin
                        accum <= '0;
                        pair  <= 2'd0;
                    end
                    CNV_IN:
                        if (cnv_cmplt) accum <= accum_in;
                    CNV_OUT:
                        if (cnv_cmplt) begin
                            accum <= accum_out;
                            if (last_pair)
                                error <= sat12({{8{accum_out[15]}}, accum_out});
                            else
                                pair <= pair + 2'd1;
                        end
                    INTG:
                        if (dec_cnt == DEC_LAST) begin
                            dec_cnt <= 4'd0;
                            intgrl  <= sat12({{11{i_sum[12]}}, i_sum});
                            if (fwd < FWD_MAX)
                                fwd <= fwd + 12'd1;
                        end else begin
                            dec_cnt <= dec_cnt + 4'd1;
                        end
                    PCALC: pcomp   <= sat12({{3{p_sh[20]}}, p_sh});
                    ICALC: icomp   <= sat12({{3{i_sh[20]}}, i_sh});
                    RHT:   rht_reg <= sat12({{10{r_sum[13]}}, r_sum});
                    LFT:   lft_reg <= sat12({{10{l_sum[13]}}, l_sum});
                    default: ;
                endcase
            end
        end
    end

    assign LEDs = error[11:4];
    assign lft  = lft_reg[11:1];
    assign rht  = rht_reg[11:1];

endmodule

// File: tb/tb_motion_cntrl_par.sv
// Directed bench: single-pair instance (INT_DEC=1) for arithmetic vectors and
// three-pair instance (INT_DEC=4, low Fwd cap) for scan/decimation/abort/reset sequences.

module tb_motion_cntrl_par;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, go_a, go_b, cnv_cmplt;
    logic [11:0] a2d_res;
    logic [7:0]  kp, ki;

    logic        a_strt, a_done;
    logic [2:0]  a_chnnl;
    logic [0:0]  a_ir;
    logic [7:0]  a_leds;
    logic [10:0] a_lft, a_rht;

    logic        b_strt, b_done;
    logic [2:0]  b_chnnl;
    logic [2:0]  b_ir;
    logic [7:0]  b_leds;
    logic [10:0] b_lft, b_rht;

    motion_cntrl_par #(
        .NUM_PAIRS(1), .SETTLE_CYC(8), .GAP_CYC(3), .INT_DEC(1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .go(go_a), .cnv_cmplt(cnv_cmplt), .A2D_res(a2d_res),
        .Kp(kp), .Ki(ki), .strt_cnv(a_strt), .chnnl(a_chnnl), .IR_en(a_ir),
        .LEDs(a_leds), .lft(a_lft), .rht(a_rht), .loop_done(a_done)
    );

    motion_cntrl_par #(
        .NUM_PAIRS(3), .SETTLE_CYC(10), .GAP_CYC(4), .INT_DEC(4), .FWD_MAX(12'h005)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .go(go_b), .cnv_cmplt(cnv_cmplt), .A2D_res(a2d_res),
        .Kp(kp), .Ki(ki), .strt_cnv(b_strt), .chnnl(b_chnnl), .IR_en(b_ir),
        .LEDs(b_leds), .lft(b_lft), .rht(b_rht), .loop_done(b_done)
    );

    logic        sel;
    logic        strt_m, done_m;
    logic [2:0]  chnnl_m;
    logic [3:0]  ir_m;
    logic [7:0]  leds_m;
    logic [10:0] lft_m, rht_m;

    assign strt_m  = sel ? b_strt  : a_strt;
    assign done_m  = sel ? b_done  : a_done;
    assign chnnl_m = sel ? b_chnnl : a_chnnl;
    assign ir_m    = sel ? {1'b0, b_ir} : {3'b000, a_ir};
    assign leds_m  = sel ? b_leds  : a_leds;
    assign lft_m   = sel ? b_lft   : a_lft;
    assign rht_m   = sel ? b_rht   : a_rht;

    int checks = 0;
    int fails  = 0;
    int b_strt_cnt = 0;
    int last_irh = 0;

    always @(negedge clk) if (b_strt) b_strt_cnt++;

    typedef struct {
        logic [11:0] inn;
        logic [11:0] outr;
        logic [7:0]  kp;
        logic [7:0]  ki;
        logic [7:0]  leds;
        logic [10:0] lft;
        logic [10:0] rht;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic conv(input logic [11:0] val, input logic [2:0] exp_ch, input int p,
                        input int hold);
        int n, rep, chg, irh;
        n = 0; rep = 0; chg = 0; irh = 0;
        while (strt_m !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("strt_seen", 32'(strt_m), 32'd1);
        chk("chnnl_in_conv", 32'(chnnl_m), 32'(exp_ch));
        chk("ir_other_bits", 32'(ir_m & ~(4'b0001 << p)), 32'd0);
        repeat (hold) begin
            @(negedge clk);
            if (strt_m) rep++;
            if (chnnl_m != exp_ch) chg++;
            if (ir_m[p]) irh++;
        end
        chk("strt_repulse", rep, 0);
        chk("chnnl_hold", chg, 0);
        last_irh = irh;
        a2d_res   = val;
        cnv_cmplt = 1'b1;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        a2d_res   = 12'hA5A;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done_m !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("loop_done", 32'(done_m), 32'd1);
    endtask

    task automatic run_loop(input int np, input logic [3:0][11:0] inv,
                            input logic [3:0][11:0] outv);
        for (int p = 0; p < np; p++) begin
            conv(inv[p], 3'(2 * p), p, 2);
            conv(outv[p], 3'(2 * p + 1), p, 2);
        end
        wait_done();
    endtask

    task automatic chk_mot(input string name, input logic [7:0] leds,
                           input logic [10:0] l, input logic [10:0] r);
        chk({name, "_leds"}, 32'(leds_m), 32'(leds));
        chk({name, "_lft"},  32'(lft_m),  32'(l));
        chk({name, "_rht"},  32'(rht_m),  32'(r));
    endtask

    initial begin
        logic [3:0][11:0] inv, outv;
        int sc0, n;

        rst_n = 1'b0; go_a = 1'b0; go_b = 1'b0; cnv_cmplt = 1'b0;
        a2d_res = '0; kp = '0; ki = '0; sel = 1'b0;

        tbl[0] = '{12'h100, 12'h000, 8'd16,  8'd0,   8'h10, 11'h080, 11'h780};
        tbl[1] = '{12'h000, 12'h040, 8'd32,  8'd0,   8'hFC, 11'h7C1, 11'h041};
        tbl[2] = '{12'hFFF, 12'h000, 8'd255, 8'd16,  8'h7F, 11'h3FF, 11'h400};
        tbl[3] = '{12'h000, 12'hFFF, 8'd1,   8'd255, 8'h80, 11'h019, 11'h7EA};
        tbl[4] = '{12'h123, 12'h123, 8'd200, 8'd0,   8'h00, 11'h002, 11'h002};

        repeat (3) @(negedge clk);
        chk("rst_a_strt",  32'(a_strt),  32'd0);
        chk("rst_a_ir",    32'(a_ir),    32'd0);
        chk("rst_a_done",  32'(a_done),  32'd0);
        chk("rst_a_lft",   32'(a_lft),   32'd0);
        chk("rst_b_chnnl", 32'(b_chnnl), 32'd0);
        chk("rst_b_leds",  32'(b_leds),  32'd0);
        chk("rst_b_rht",   32'(b_rht),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single-pair instance: one loop per table row, state carries across rows
        go_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            kp = tbl[i].kp;
            ki = tbl[i].ki;
            inv = '0; outv = '0;
            inv[0]  = tbl[i].inn;
            outv[0] = tbl[i].outr;
            run_loop(1, inv, outv);
            chk_mot($sformatf("row%0d", i), tbl[i].leds, tbl[i].lft, tbl[i].rht);
        end

        // stray cnv_cmplt in SETTLE, then a long wait in CNV_IN
        kp = 8'd0; ki = 8'd0;
        @(negedge clk);
        a2d_res = 12'hFFF; cnv_cmplt = 1'b1;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        conv(12'h010, 3'd0, 0, 1000);
        chk("ir_duty_1000", 32'((last_irh >= 536 && last_irh <= 560) ? 1 : 0), 32'd1);
        conv(12'h000, 3'd1, 0, 2);
        wait_done();
        chk_mot("hold", 8'h01, 11'h003, 11'h003);

        go_a = 1'b0;
        @(negedge clk);
        chk("abort_a_lft",  32'(a_lft),  32'd0);
        chk("abort_a_rht",  32'(a_rht),  32'd0);
        chk("abort_a_leds", 32'(a_leds), 32'h01);

        // three-pair instance
        sel = 1'b1;
        sc0 = b_strt_cnt;
        go_b = 1'b1;
        inv = '0; outv = '0;
        for (int p = 0; p < 3; p++) inv[p] = 12'hFFF;
        run_loop(3, inv, outv);
        chk("scan_strt_count", b_strt_cnt - sc0, 6);
        chk_mot("sat", 8'h7F, 11'h000, 11'h000);

        inv = '0; outv = '0;
        inv[0] = 12'h010; inv[1] = 12'h020; inv[2] = 12'h040;
        run_loop(3, inv, outv);
        chk_mot("weight_in", 8'h15, 11'h000, 11'h000);

        inv = '0; outv = '0;
        inv[0] = 12'h100; outv[2] = 12'h010;
        run_loop(3, inv, outv);
        chk_mot("weight_out", 8'h0C, 11'h000, 11'h000);

        for (int l = 4; l <= 28; l++) begin
            run_loop(3, '0, '0);
            if (l == 8)
                chk_mot("dec_loop8", 8'h00, 11'h001, 11'h001);
            else if (l == 16 || l == 28)
                chk_mot($sformatf("fwd_loop%0d", l), 8'h00, 11'h002, 11'h002);
        end

        // abort in GAP of pair 1
        conv(12'h000, 3'd0, 0, 2);
        conv(12'h000, 3'd1, 0, 2);
        conv(12'h000, 3'd2, 1, 2);
        chk("gap_chnnl", 32'(b_chnnl), 32'd3);
        go_b = 1'b0;
        @(negedge clk);
        chk("abort_strt",  32'(b_strt),  32'd0);
        chk("abort_ir",    32'(b_ir),    32'd0);
        chk("abort_chnnl", 32'(b_chnnl), 32'd0);
        chk("abort_lft",   32'(b_lft),   32'd0);
        chk("abort_rht",   32'(b_rht),   32'd0);

        go_b = 1'b1;
        for (int l = 1; l <= 8; l++) begin
            run_loop(3, '0, '0);
            if (l == 7)
                chk_mot("restart7", 8'h00, 11'h000, 11'h000);
            else if (l == 8)
                chk_mot("restart8", 8'h00, 11'h001, 11'h001);
        end

        // reset while waiting in CNV_OUT of pair 1
        conv(12'h000, 3'd0, 0, 2);
        conv(12'h000, 3'd1, 0, 2);
        conv(12'h000, 3'd2, 1, 2);
        n = 0;
        while (b_strt !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("cnv_out_strt", 32'(b_strt), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_strt",  32'(b_strt),  32'd0);
        chk("rst_mid_ir",    32'(b_ir),    32'd0);
        chk("rst_mid_chnnl", 32'(b_chnnl), 32'd0);
        chk("rst_mid_lft",   32'(b_lft),   32'd0);
        chk("rst_mid_rht",   32'(b_rht),   32'd0);
        chk("rst_mid_done",  32'(b_done),  32'd0);
        chk("rst_a_leds_clr", 32'(a_leds), 32'd0);
        rst_n = 1'b1;
        go_b  = 1'b0;
        a2d_res = 12'hFFF; cnv_cmplt = 1'b1;
        @(negedge clk);
        cnv_cmplt = 1'b0;
        @(negedge clk);
        chk("late_cmplt_strt", 32'(b_strt), 32'd0);
        go_b = 1'b1;
        n = 0;
        while (b_strt !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("settle_len", n, 11);
        run_loop(3, '0, '0);
        chk_mot("post_rst", 8'h00, 11'h000, 11'h000);

        go_b = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
